raytracing_line_scheduler: RTL

- Sequences one raytraced scan line per VGA line request across the worker array: latches the target row, launches all workers, waits for them to finish, then pulses a commit that copies the worker buffer to the display line.
- Also provides a safe window for scene (sphere) updates from SPI, a watchdog, and error/status reporting.
- Sits between the VGA timing block, the worker array and the line buffers.

---
 rtl/raytracing_line_scheduler_pkg.sv | 29 ++
 rtl/raytracing_line_scheduler_sched_watchdog.sv | 30 +++
 rtl/raytracing_line_scheduler.sv | 108 ++++++++++
 3 files changed

// File: rtl/raytracing_line_scheduler_pkg.sv
// Shared types and constants for the raytracing line scheduler and its neighbours.
package raytracing_line_scheduler_pkg;

   localparam int Y_OFFSET       = 240;
   localparam int TIMEOUT_CYCLES = 4000;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LAUNCH   = 3'd1,
      WAIT_ACK = 3'd2,
      RUN      = 3'd3,
      COMMIT   = 3'd4
   } sched_state_t;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } color_t;

   typedef struct packed {
      logic signed [11:0] x;
      logic signed [11:0] y;
      logic signed [11:0] z;
      logic        [11:0] radius;
      color_t             color;
   } sphere_t;

endpackage

// File: rtl/raytracing_line_scheduler_sched_watchdog.sv
// Loadable down-counter; o_expire marks the last allowed cycle of a running line.
module sched_watchdog #(
   parameter int TIMEOUT_CYCLES = 4000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_load,
   input  logic i_run,
   output logic o_expire
);

   localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] r_cnt;

   // Loaded with TIMEOUT-1 so the Nth running cycle is the one that expires.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= LOAD_VAL;
      end else if (i_run && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_expire = i_run && (r_cnt == '0);

endmodule

// File: rtl/raytracing_line_scheduler.sv
// Launches the worker array once per VGA line request and commits the finished line.
module raytracing_line_scheduler #(
   parameter int N_WORKERS      = 10,
   parameter int Y_OFFSET       = raytracing_line_scheduler_pkg::Y_OFFSET,
   parameter int TIMEOUT_CYCLES = raytracing_line_scheduler_pkg::TIMEOUT_CYCLES,
   parameter int CNT_W          = 16
) (
   input  logic                 CLK100MHZ,
   input  logic                 ck_rst,
   input  logic                 line_req,
   input  logic [11:0]          next_y,
   input  logic [N_WORKERS-1:0] worker_busy,
   output logic                 worker_activate,
   output logic [11:0]          pixel_y,
   output logic                 commit,
   output logic                 scene_load_en,
   output logic                 timeout_err,
   output logic                 overrun_err,
   output logic [CNT_W-1:0]     lines_done,
   output logic [2:0]           state_dbg
);

   import raytracing_line_scheduler_pkg::*;

   sched_state_t     r_state, w_next;
   logic             r_req_q, r_pending, r_scene, r_timeout, r_overrun;
   logic [11:0]      r_pixel_y;
   logic [CNT_W-1:0] r_lines;
   logic             w_req_edge, w_all_idle, w_all_busy, w_start;
   logic             w_wd_load, w_wd_run, w_wd_expire;

   assign w_req_edge = line_req & ~r_req_q;
   assign w_all_idle = (worker_busy == '0);
   assign w_all_busy = &worker_busy;
   assign w_start    = (r_state == IDLE) && (w_req_edge || r_pending);
   assign w_wd_run   = (r_state == WAIT_ACK) || (r_state == RUN);
   assign w_wd_load  = (r_state == LAUNCH) && w_all_idle;

   sched_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
      .i_clk    (CLK100MHZ),
      .i_rst    (ck_rst),
      .i_load   (w_wd_load),
      .i_run    (w_wd_run),
      .o_expire (w_wd_expire)
   );

   always_ff @(posedge CLK100MHZ or posedge ck_rst) begin
      if (ck_rst) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // Watchdog expiry takes priority over normal progress in WAIT_ACK and RUN.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:     if (w_start) w_next = LAUNCH;
         LAUNCH:   if (w_all_idle) w_next = WAIT_ACK;
         WAIT_ACK: begin
            if (w_wd_expire)     w_next = IDLE;
            else if (w_all_busy) w_next = RUN;
         end
         RUN: begin
            if (w_wd_expire)     w_next = IDLE;
            else if (w_all_idle) w_next = COMMIT;
         end
         COMMIT:   w_next = IDLE;
         default:  w_next = IDLE;
      endcase
   end

   always_comb begin
      worker_activate = (r_state == WAIT_ACK);
      commit          = (r_state == COMMIT);
      state_dbg       = r_state;
   end

   // A request arriving mid-line is held in r_pending; a second one is lost and flagged.
   always_ff @(posedge CLK100MHZ or posedge ck_rst) begin
      if (ck_rst) begin
         r_req_q   <= 1'b0;
         r_pending <= 1'b0;
         r_scene   <= 1'b0;
         r_timeout <= 1'b0;
         r_overrun <= 1'b0;
         r_pixel_y <= '0;
         r_lines   <= '0;
      end else begin
         r_req_q <= line_req;
         r_scene <= (r_state == IDLE) & ~r_pending & ~w_req_edge;
         if (w_start) r_pixel_y <= next_y - 12'(Y_OFFSET);
         if (r_state == IDLE) begin
            r_pending <= r_pending & w_req_edge;
         end else if (w_req_edge) begin
            if (r_pending) r_overrun <= 1'b1;
            else           r_pending <= 1'b1;
         end
         if (w_wd_expire) r_timeout <= 1'b1;
         if (r_state == COMMIT) r_lines <= r_lines + 1'b1;
      end
   end

   assign pixel_y       = r_pixel_y;
   assign scene_load_en = r_scene;
   assign timeout_err   = r_timeout;
   assign overrun_err   = r_overrun;
   assign lines_done    = r_lines;

endmodule
